// File: rtl/xg_lsu_serial.sv
// ---------------------------------------------------------------------------
// xg_lsu_serial
//
// Load/store sequencer between the core's MEM stage and a byte-wide data
// memory. It accepts one load or store per transaction and splits it into
// single-byte memory accesses, one per cycle. Because of this, misaligned
// half and word accesses need no special treatment. Load bytes are assembled
// little-endian, sign- or zero-extended, and returned on a response channel.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds valid and its payload stable until that edge.
//   The consumer may change ready at any time. The request channel ignores
//   req_valid whenever req_ready is low, so the request stays pending
//   upstream. resp_ready has no effect unless resp_valid is high.
//
// Ports:
//   clk, rstn          clock (rising edge) and async active-low reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned       loads: 1 zero-extend, 0 sign-extend
//   req_addr           byte address; values >= 2^MEM_AWIDTH are errors
//   req_wdata          store data; the low bytes are used
//   mem_addr           byte address to the memory
//   mem_we             byte write strobe (memory writes on the rising edge)
//   mem_wdata          byte to write
//   mem_rdata          combinational read byte at mem_addr
//   resp_valid/ready   response handshake
//   resp_rdata         extended load data; 0 for stores and errors
//   resp_err           request rejected (bad size or out of range)
//   dbg_state          current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module xg_lsu_serial #(
  parameter int XLEN       = 32,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  // Held low while reset is asserted. It rises on the first clock after
  // release, so req_ready stays low for the whole reset period even though
  // the state register already reads IDLE.
  logic started;

  // Latched request fields
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [MEM_AWIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  err_q;

  // Byte counter within the transaction and the load assembly register
  logic [1:0]            cnt;
  logic [XLEN-1:0]       data_q;

  logic                  accept;
  logic                  req_error;
  logic [1:0]            last_idx;
  logic                  last_byte;
  logic [XLEN-1:0]       ext_data;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign accept = req_valid && req_ready;

  // Any address bit above the memory's byte-address width puts the request
  // out of range.
  assign req_error = (req_size == 2'b11) || (|req_addr[XLEN-1:MEM_AWIDTH]);

  // Index of the final byte: byte -> 0, half -> 1, word -> 3.
  always_comb begin
    last_idx = 2'd0;
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  assign last_byte = (cnt == last_idx);

  // -------------------------------------------------------------------------
  // Load extension. A sign bit is only replicated for signed loads.
  // -------------------------------------------------------------------------
  always_comb begin
    ext_data = data_q;
    case (size_q)
      2'b00:   ext_data = {{(XLEN-8){data_q[7] & ~uns_q}}, data_q[7:0]};
      2'b01:   ext_data = {{(XLEN-16){data_q[15] & ~uns_q}}, data_q[15:0]};
      default: ext_data = data_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_n;
      started <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs. The memory-side outputs are forced to zero
  // outside ACCESS, so an asynchronous reset (which returns the FSM to IDLE)
  // silences them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;

    case (state)
      S_IDLE: begin
        req_ready = started;
        if (accept) begin
          state_n = req_error ? S_RESP : S_ACCESS;
        end
      end

      S_ACCESS: begin
        // The add truncates to MEM_AWIDTH bits, which gives the required
        // wrap from the top byte back to address 0.
        mem_addr = addr_q + MEM_AWIDTH'(cnt);
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q[8*cnt +: 8];
        end
        if (last_byte) begin
          state_n = S_RESP;
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ext_data;
        if (resp_ready) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch, byte counter and load assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= 2'd0;
      data_q  <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[MEM_AWIDTH-1:0];
        wdata_q <= req_wdata;
        err_q   <= req_error;
        cnt     <= 2'd0;
        data_q  <= '0;
      end else if (state == S_ACCESS) begin
        if (!we_q) begin
          data_q[8*cnt +: 8] <= mem_rdata;
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign dbg_state = state;

endmodule
